// File: rtl/pt_train_sched.sv
// Perceptron training scheduler: queues resolved-branch training requests and
// serialises them through a shared table read port into one-cycle trainer writes.
module pt_train_sched #(
  parameter int unsigned BHR_W    = 8,
  parameter int unsigned PT_IDX_W = 6,
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned THETA    = 30,
  parameter int unsigned QD       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_vld_i,
  output logic                req_rdy_o,
  input  logic [PT_IDX_W-1:0] req_idx_i,
  input  logic                req_outcome_i,
  input  logic                req_pred_i,
  input  logic [WEIGHT_W-1:0] req_y_i,
  input  logic [BHR_W-1:0]    req_bhr_i,
  output logic                pt_rd_en_o,
  output logic [PT_IDX_W-1:0] pt_rd_idx_o,
  input  logic                pt_rd_gnt_i,
  output logic                tr_en_o,
  output logic [PT_IDX_W-1:0] tr_idx_o,
  output logic                tr_outcome_o,
  output logic [BHR_W-1:0]    tr_bhr_o,
  output logic                busy_o,
  output logic [15:0]         train_cnt_o
);

  localparam int unsigned PtrW = (QD > 1) ? $clog2(QD) : 1;
  localparam int unsigned CntW = $clog2(QD + 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e state_q, state_d;

  logic [PT_IDX_W-1:0] idx_mem [QD];
  logic                out_mem [QD];
  logic [BHR_W-1:0]    bhr_mem [QD];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     train_cnt_q;

  logic            accept, push, pop;
  logic [WEIGHT_W:0] y_ext, y_abs;

  // One extra bit so the most-negative output has a representable magnitude.
  assign y_ext = {req_y_i[WEIGHT_W-1], req_y_i};
  assign y_abs = y_ext[WEIGHT_W] ? -y_ext : y_ext;

  assign req_rdy_o = (count_q != CntW'(QD));
  assign accept    = req_vld_i & req_rdy_o;
  // Confident correct predictions are accepted but never trained.
  assign push      = accept & ((req_outcome_i != req_pred_i) | (32'(y_abs) <= THETA));
  assign pop       = (state_q == StWrite);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      train_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PtrW'(1);
        train_cnt_q <= train_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr_q] <= req_idx_i;
      out_mem[wr_ptr_q] <= req_outcome_i;
      bhr_mem[wr_ptr_q] <= req_bhr_i;
    end
  end

  // Leaving WRITE only re-enters READ for entries already queued before the pop,
  // so a request arriving during WRITE still sees the full IDLE->READ latency.
  always_comb begin
    state_d    = state_q;
    pt_rd_en_o = 1'b0;
    tr_en_o    = 1'b0;
    unique case (state_q)
      StIdle:  if (count_q != '0) state_d = StRead;
      StRead: begin
        pt_rd_en_o = 1'b1;
        if (pt_rd_gnt_i) state_d = StWrite;
      end
      StWrite: begin
        tr_en_o = 1'b1;
        state_d = (count_q > CntW'(1)) ? StRead : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign pt_rd_idx_o  = idx_mem[rd_ptr_q];
  assign tr_idx_o     = idx_mem[rd_ptr_q];
  assign tr_outcome_o = out_mem[rd_ptr_q];
  assign tr_bhr_o     = bhr_mem[rd_ptr_q];
  assign busy_o       = (state_q != StIdle) || (count_q != '0);
  assign train_cnt_o  = train_cnt_q;

endmodule

// File: tb/tb_pt_train_sched.sv
// Bench for pt_train_sched: directed and random requests checked each cycle
// against a queue-based timing model of the training schedule.
module tb_pt_train_sched;

  localparam int BHR_W    = 8;
  localparam int PT_IDX_W = 6;
  localparam int WEIGHT_W = 8;
  localparam int THETA    = 30;
  localparam int QD       = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_vld_i, req_rdy_o;
  logic [PT_IDX_W-1:0] req_idx_i;
  logic                req_outcome_i, req_pred_i;
  logic [WEIGHT_W-1:0] req_y_i;
  logic [BHR_W-1:0]    req_bhr_i;
  logic                pt_rd_en_o, pt_rd_gnt_i, tr_en_o, tr_outcome_o, busy_o;
  logic [PT_IDX_W-1:0] pt_rd_idx_o, tr_idx_o;
  logic [BHR_W-1:0]    tr_bhr_o;
  logic [15:0]         train_cnt_o;

  always #5 clk = ~clk;

  pt_train_sched #(
    .BHR_W(BHR_W), .PT_IDX_W(PT_IDX_W), .WEIGHT_W(WEIGHT_W), .THETA(THETA), .QD(QD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_idx_i(req_idx_i),
    .req_outcome_i(req_outcome_i), .req_pred_i(req_pred_i), .req_y_i(req_y_i),
    .req_bhr_i(req_bhr_i),
    .pt_rd_en_o(pt_rd_en_o), .pt_rd_idx_o(pt_rd_idx_o), .pt_rd_gnt_i(pt_rd_gnt_i),
    .tr_en_o(tr_en_o), .tr_idx_o(tr_idx_o), .tr_outcome_o(tr_outcome_o),
    .tr_bhr_o(tr_bhr_o), .busy_o(busy_o), .train_cnt_o(train_cnt_o)
  );

  typedef struct {
    logic [PT_IDX_W-1:0] idx;
    logic                outc;
    logic [BHR_W-1:0]    bhr;
    int                  enq;
  } ent_t;

  ent_t q[$];
  int   cyc, last_write, exp_cnt, total, bad;
  bit   wr_pend, acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit trains(input logic outc, input logic pred, input logic [7:0] y);
    int yi = int'($signed(y));
    int a  = (yi < 0) ? -yi : yi;
    return (outc != pred) || (a <= THETA);
  endfunction

  function automatic void model_reset();
    q.delete();
    wr_pend    = 1'b0;
    last_write = -100;
    exp_cnt    = 0;
    cyc        = 0;
  endfunction

  // Called 1 time unit after a rising edge: checks cycle cyc, drives it, advances.
  // An entry's read phase starts no earlier than two cycles after it is queued
  // and the cycle after the previous write; its write follows the first grant.
  task automatic step(input bit vld, input logic [5:0] idx, input bit outc, input bit pred,
                      input logic [7:0] y, input logic [7:0] bhr, input bit gnt,
                      output bit accepted);
    bit e_rd, e_tr, e_rdy;
    int rs;
    e_tr  = wr_pend;
    e_rdy = (q.size() != QD);
    e_rd  = 1'b0;
    if (!wr_pend && q.size() > 0) begin
      rs = q[0].enq + 2;
      if (last_write + 1 > rs) rs = last_write + 1;
      e_rd = (cyc >= rs);
    end
    chk("req_rdy", 32'(req_rdy_o), 32'(e_rdy));
    chk("pt_rd_en", 32'(pt_rd_en_o), 32'(e_rd));
    chk("tr_en", 32'(tr_en_o), 32'(e_tr));
    chk("busy", 32'(busy_o), 32'(q.size() != 0));
    chk("train_cnt", 32'(train_cnt_o), 32'(exp_cnt[15:0]));
    if (e_rd) chk("pt_rd_idx", 32'(pt_rd_idx_o), 32'(q[0].idx));
    if (e_tr) begin
      chk("tr_idx", 32'(tr_idx_o), 32'(q[0].idx));
      chk("tr_outcome", 32'(tr_outcome_o), 32'(q[0].outc));
      chk("tr_bhr", 32'(tr_bhr_o), 32'(q[0].bhr));
    end
    req_vld_i     = vld;
    req_idx_i     = idx;
    req_outcome_i = outc;
    req_pred_i    = pred;
    req_y_i       = y;
    req_bhr_i     = bhr;
    pt_rd_gnt_i   = gnt;
    if (e_tr) begin
      void'(q.pop_front());
      last_write = cyc;
      exp_cnt++;
      wr_pend = 1'b0;
    end
    if (e_rd && gnt) wr_pend = 1'b1;
    accepted = vld && e_rdy;
    if (accepted && trains(outc, pred, y)) q.push_back('{idx, outc, bhr, cyc});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit gnt);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, gnt, a);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(pt_rd_en_o), 32'd0);
    chk({tag, "_tr_en"}, 32'(tr_en_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_rdy"}, 32'(req_rdy_o), 32'd1);
    chk({tag, "_cnt"}, 32'(train_cnt_o), 32'd0);
  endtask

  initial begin
    int guard;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    req_vld_i = 1'b0; req_idx_i = '0; req_outcome_i = 1'b0; req_pred_i = 1'b0;
    req_y_i = '0; req_bhr_i = '0; pt_rd_gnt_i = 1'b0;
    #1;
    chk_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Mispredict, y=-50, idx 5, grant held.
    step(1'b1, 6'd5, 1'b1, 1'b0, 8'hCE, 8'hA5, 1'b1, acc);
    idle(6, 1'b1);

    // Confidence threshold: +31 discarded, +30 trained, -128 discarded.
    step(1'b1, 6'd7, 1'b1, 1'b1, 8'h1F, 8'h11, 1'b1, acc);
    idle(5, 1'b1);
    step(1'b1, 6'd8, 1'b0, 1'b0, 8'h1E, 8'h22, 1'b1, acc);
    idle(5, 1'b1);
    step(1'b1, 6'd9, 1'b1, 1'b1, 8'h80, 8'h33, 1'b1, acc);
    idle(5, 1'b1);

    // Five back-to-back mispredicts with grant low; fifth stalls until drained.
    for (int i = 0; i < 5; i++) begin
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
        step(1'b1, 6'(10 + i), 1'b1, 1'b0, 8'hCE, 8'(i * 17), guard >= 3, acc);
        guard++;
      end
      if (!acc) chk("stall_bound", 32'd0, 32'd1);
    end
    idle(25, 1'b1);

    // Grant withheld twice in READ, then granted.
    step(1'b1, 6'd21, 1'b0, 1'b1, 8'h05, 8'h44, 1'b0, acc);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(4, 1'b0);

    // Same index back-to-back.
    step(1'b1, 6'd3, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, acc);
    step(1'b1, 6'd3, 1'b0, 1'b1, 8'h00, 8'h02, 1'b1, acc);
    idle(10, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           $urandom_range(0, 3) != 0, acc);
    end
    idle(30, 1'b1);

    // Asynchronous reset while stuck in READ with three entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 6'(30 + i), 1'b1, 1'b0, 8'h90, 8'h55, 1'b0, acc);
    idle(3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(12, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pt_train_sched.md
PT_TRAIN_SCHED -- requirements
Module: pt_train_sched

Interface
REQ-001 SHALL have parameter BHR_W, default 8, meaning global history length.
REQ-002 SHALL have parameter PT_IDX_W, default 6, meaning perceptron-table index width.
REQ-003 SHALL have parameter WEIGHT_W, default 8, meaning signed perceptron output width.
REQ-004 SHALL have parameter THETA, default 30, meaning unsigned training threshold.
REQ-005 SHALL have parameter QD, default 4, meaning request-queue depth (power of 2, >=2).
REQ-006 SHALL have port clk  in  1  clock. One clock; all logic on posedge clk.
REQ-007 SHALL have port rst  in  1  reset. Asynchronous, active-high.
REQ-008 SHALL have port req_vld_i  in  1  resolved-branch training request from FU.
REQ-009 SHALL have port req_rdy_o  out  1  request accepted when high together with req_vld_i.
REQ-010 SHALL have port req_idx_i  in  PT_IDX_W  table index of the resolved branch.
REQ-011 SHALL have port req_outcome_i  in  1  actual direction, 1 = taken.
REQ-012 SHALL have port req_pred_i  in  1  predicted direction.
REQ-013 SHALL have port req_y_i  in  WEIGHT_W  signed perceptron output used for prediction.
REQ-014 SHALL have port req_bhr_i  in  BHR_W  history used for prediction.
REQ-015 SHALL have port pt_rd_en_o  out  1  request for the shared table read port.
REQ-016 SHALL have port pt_rd_idx_o  out  PT_IDX_W  read index; head-of-queue index.
REQ-017 SHALL have port pt_rd_gnt_i  in  1  read port granted this cycle (fetch has priority).
REQ-018 SHALL have port tr_en_o  out  1  one-cycle training/write enable to the trainer.
REQ-019 SHALL have port tr_idx_o, tr_outcome_o, tr_bhr_o  out  PT_IDX_W/1/BHR_W  head-entry fields.
REQ-020 SHALL have port busy_o  out  1  high when state != IDLE or queue non-empty.
REQ-021 SHALL have port train_cnt_o  out  16  count of completed trainings, wraps at 2^16.

Function
REQ-022 SHALL hold a FIFO of QD entries {idx, outcome, bhr} with a count of 0..QD.
REQ-023 SHALL drive req_rdy_o = (count != QD), from registered count only; no same-cycle pop bypass.
REQ-024 SHALL compute |req_y_i| in WEIGHT_W+1 bits (most-negative value gives 2^(WEIGHT_W-1), no overflow).
REQ-025 SHALL enqueue an accepted request only if req_outcome_i != req_pred_i or |req_y_i| <= THETA; otherwise accept and discard.
REQ-026 SHALL implement FSM IDLE, READ, WRITE with registered state.
REQ-027 IDLE: count>0 -> READ; else stay.
REQ-028 READ: pt_rd_en_o=1; pt_rd_gnt_i=1 -> WRITE; else stay in READ, index held.
REQ-029 WRITE: tr_en_o=1 for exactly one cycle; head popped at that edge; train_cnt_o increments; next READ if count after pop >0, else IDLE.
REQ-030 SHALL drive pt_rd_en_o and tr_en_o low in all other states; tr_* fields show head entry whenever tr_en_o is high.
REQ-031 SHALL handle enqueue and pop in the same cycle: count unchanged, both pointers advance, pointers wrap mod QD.
REQ-032 SHALL give minimum latency of 3 cycles from request acceptance (cycle t) to tr_en_o (cycle t+3) with grant held high.
REQ-033 SHALL serialize back-to-back same-index entries: the second READ occurs the cycle after the first WRITE, so it observes updated weights.

Reset
REQ-034 SHALL, on rst assertion and independent of clk: state=IDLE, count=0, pointers=0, train_cnt_o=0, pt_rd_en_o=0, tr_en_o=0, busy_o=0, req_rdy_o=1.
REQ-035 SHALL drop all queued and in-flight requests on reset mid-operation; no tr_en_o pulse follows reset.

Verification
REQ-036 Mispredict (outcome=1, pred=0, y=-50, idx=5), grant held 1 -> pt_rd_en_o at t+2 with idx 5, tr_en_o at t+3 with tr_idx_o=5, train_cnt_o=1.
REQ-037 Correct prediction with y=+31 (THETA=30) -> accepted, no pt_rd_en_o, busy_o stays 0; y=+30 or y=-128 (8-bit) -> trains or discards per REQ-024/025 (-128 -> discarded).
REQ-038 Five mispredicts on consecutive cycles, grant held 0 -> req_rdy_o drops after 4th accept, 5th stalled; release grant -> 4 tr_en_o pulses in FIFO order, then 5th.
REQ-039 Grant toggles 0,0,1 in READ -> pt_rd_en_o high 3 cycles, pt_rd_idx_o stable, single tr_en_o.
REQ-040 Two same-index entries queued -> tr_en_o pulses separated by >=2 cycles, READ-after-WRITE ordering per REQ-033.
REQ-041 Assert rst asynchronously during READ with 3 entries queued -> outputs per REQ-034 immediately; no tr_en_o after deassertion.
